bist_misr_checker: RTL and testbench

BIST response compactor downstream of the pseudo-random pattern generator. It folds every valid beat of the pattern/response stream into a multiple-input signature register (MISR) and counts the beats. When the source signals completion, it compares the final signature and beat count against golden values and reports a sticky pass/fail result. The inputs connect directly to the generator's `valid_o`/`data_o`/`done_o`, or to the array output bus under the same protocol.

---
 rtl/bist_misr_pkg.sv | 14 +
 rtl/bist_misr_checker_misr.sv | 34 +++
 rtl/bist_misr_checker.sv | 123 ++++++++++++
 tb/tb_bist_misr_checker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_misr_pkg.sv
// Shared types and constants for the BIST signature checker.
package bist_misr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } st_misr_state;

  // x^64 + x^4 + x^3 + x + 1; narrower instances take the low bits.
  localparam logic [63:0] DEFAULT_POLY = 64'h0000_0000_0000_001B;

endpackage

// File: rtl/bist_misr_checker_misr.sv
// Multiple-input signature register: shift left, reduce by POLY, fold in data.
module misr
  import bist_misr_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] POLY       = DEFAULT_POLY[DATA_WIDTH-1:0],
  parameter logic [DATA_WIDTH-1:0] SEED       = '0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  init_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] sig_o
);

  function automatic logic [DATA_WIDTH-1:0] misr_next(
    input logic [DATA_WIDTH-1:0] sig,
    input logic [DATA_WIDTH-1:0] din
  );
    return {sig[DATA_WIDTH-2:0], 1'b0} ^ (sig[DATA_WIDTH-1] ? POLY : '0) ^ din;
  endfunction

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sig_o <= SEED;
    end else if (init_i) begin
      sig_o <= SEED;
    end else if (en_i) begin
      sig_o <= misr_next(sig_o, data_i);
    end
  end

endmodule

// File: rtl/bist_misr_checker.sv
// BIST response compactor: MISR + beat counter + golden compare with sticky result.
// Optional idle timeout enabled by defining BIST_MISR_TIMEOUT_EN.
module bist_misr_checker
  import bist_misr_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    CNT_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] POLY       = DEFAULT_POLY[DATA_WIDTH-1:0],
  parameter logic [DATA_WIDTH-1:0] SEED       = '0
`ifdef BIST_MISR_TIMEOUT_EN
  ,
  parameter int                    TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic [DATA_WIDTH-1:0] golden_sig_i,
  input  logic [CNT_WIDTH-1:0]  expected_cnt_i,
  output logic [DATA_WIDTH-1:0] signature_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o
`ifdef BIST_MISR_TIMEOUT_EN
  ,
  output logic                  timeout_o
`endif
);

  st_misr_state state;
  logic         accept;

  function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // A start pulse re-seeds the MISR, so a beat in that cycle is dropped.
  assign accept = (state == COMPACT) && valid_i && !start_i;

  misr #(
    .DATA_WIDTH (DATA_WIDTH),
    .POLY       (POLY),
    .SEED       (SEED)
  ) u_misr (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .init_i (start_i),
    .en_i   (accept),
    .data_i (data_i),
    .sig_o  (signature_o)
  );

`ifdef BIST_MISR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] idle_cnt;
  logic             tmo_hit;

  assign tmo_hit = (state == COMPACT) && (idle_cnt == TMO_W'(TIMEOUT_CYCLES));
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      count_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      pass_o  <= 1'b0;
`ifdef BIST_MISR_TIMEOUT_EN
      idle_cnt  <= '0;
      timeout_o <= 1'b0;
`endif
    end else if (start_i) begin
      state   <= COMPACT;
      count_o <= '0;
      busy_o  <= 1'b1;
      done_o  <= 1'b0;
      pass_o  <= 1'b0;
`ifdef BIST_MISR_TIMEOUT_EN
      idle_cnt  <= '0;
      timeout_o <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: ;
        COMPACT: begin
          if (accept) begin
            count_o <= cnt_sat_inc(count_o);
          end
`ifdef BIST_MISR_TIMEOUT_EN
          idle_cnt <= valid_i ? '0 : idle_cnt + 1'b1;
          if (last_i) begin
            state <= CHECK;
          end else if (tmo_hit) begin
            state     <= CHECK;
            timeout_o <= 1'b1;
          end
`else
          if (last_i) begin
            state <= CHECK;
          end
`endif
        end
        CHECK: begin
          state  <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
`ifdef BIST_MISR_TIMEOUT_EN
          pass_o <= (signature_o == golden_sig_i) && (count_o == expected_cnt_i) && !timeout_o;
`else
          pass_o <= (signature_o == golden_sig_i) && (count_o == expected_cnt_i);
`endif
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_misr_checker.sv
// Self-checking bench for bist_misr_checker (8-bit data, POLY 0x1D, 4-bit count).
module tb_bist_misr_checker;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start, valid, last;
  logic [W-1:0]  data, golden;
  logic [CW-1:0] exp_cnt;
  logic [W-1:0]  sig;
  logic [CW-1:0] cnt;
  logic          busy, done, pass;
`ifdef BIST_MISR_TIMEOUT_EN
  logic          tmo;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: signature as a polynomial residue, count as an integer.
  int unsigned m_sig;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  bist_misr_checker #(
    .DATA_WIDTH (W),
    .CNT_WIDTH  (CW),
    .POLY       (8'h1D),
    .SEED       (8'h00)
`ifdef BIST_MISR_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .start_i        (start),
    .valid_i        (valid),
    .data_i         (data),
    .last_i         (last),
    .golden_sig_i   (golden),
    .expected_cnt_i (exp_cnt),
    .signature_o    (sig),
    .count_o        (cnt),
    .busy_o         (busy),
    .done_o         (done),
    .pass_o         (pass)
`ifdef BIST_MISR_TIMEOUT_EN
    ,
    .timeout_o      (tmo)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Multiply by x and add data, reduced modulo x^8 + x^4 + x^3 + x^2 + 1.
  function automatic int unsigned ref_fold(input int unsigned s, input int unsigned d);
    int unsigned t;
    t = (s * 2) ^ d;
    if (t >= 256) t = t ^ 32'h11D;
    return t;
  endfunction

  function automatic int unsigned ref_inc(input int unsigned c);
    return (c >= (1 << CW) - 1) ? c : c + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; valid = 1'b0; last = 1'b0; data = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_sig = 0;
    m_cnt = 0;
  endtask

  // Directed stream 01, 02, 80, 00 with a given golden pair.
  task automatic run_stream(input logic [W-1:0] g, input logic [CW-1:0] e, input logic p, input string tag);
    logic [W-1:0] beats [4];
    logic [W-1:0] steps [4];
    beats = '{8'h01, 8'h02, 8'h80, 8'h00};
    steps = '{8'h01, 8'h00, 8'h80, 8'h1D};
    golden = g; exp_cnt = e;
    do_start();
    check({tag, "_busy_after_start"}, busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; data = beats[i];
      tick();
      check({tag, "_sig_step"}, sig, steps[i]);
    end
    valid = 1'b0; last = 1'b1;
    tick();
    last = 1'b0;
    check({tag, "_check_not_done"}, {busy, done}, 2'b10);
    tick();
    check({tag, "_done"}, {busy, done}, 2'b01);
    check({tag, "_pass"}, pass, p);
    check({tag, "_count"}, cnt, 4);
  endtask

  // Random run: beats with gaps, optional beat on last, random golden correctness.
  task automatic run_random(input int nb);
    logic [W-1:0] q [$];
    int unsigned  f_sig, f_cnt;
    int           mode;
    logic         last_has_beat, exp_pass;
    q = {};
    for (int i = 0; i < nb; i++) q.push_back(W'($urandom));
    last_has_beat = (nb > 0) && ($urandom_range(0, 1) == 1);
    f_sig = 0; f_cnt = 0;
    foreach (q[i]) begin
      f_sig = ref_fold(f_sig, q[i]);
      f_cnt = ref_inc(f_cnt);
    end
    mode = $urandom_range(0, 3);
    golden  = (mode == 1) ? W'(f_sig) ^ W'($urandom_range(1, 255)) : W'(f_sig);
    exp_cnt = (mode == 2) ? CW'(f_cnt + 1) : CW'(f_cnt);
    exp_pass = (mode == 0) || (mode == 3);
    do_start();
    check("rnd_start_sig", sig, 0);
    check("rnd_start_cnt", cnt, 0);
    for (int i = 0; i < nb; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) begin
        valid = 1'b0; data = W'($urandom);
        tick();
        check("rnd_gap_sig", sig, m_sig);
      end
      valid = 1'b1; data = q[i];
      last  = last_has_beat && (i == nb - 1);
      m_sig = ref_fold(m_sig, q[i]);
      m_cnt = ref_inc(m_cnt);
      tick();
      check("rnd_sig", sig, m_sig);
      check("rnd_cnt", cnt, m_cnt);
    end
    if (!last_has_beat) begin
      valid = 1'b0; last = 1'b1;
      tick();
    end
    valid = 1'b0; last = 1'b0;
    check("rnd_check_state", {busy, done}, 2'b10);
    valid = 1'b1; data = W'($urandom);
    tick();
    check("rnd_done", {busy, done}, 2'b01);
    check("rnd_pass", pass, exp_pass);
    check("rnd_final_sig", sig, f_sig);
    tick();
    valid = 1'b0;
    check("rnd_done_ignores_beat", {sig, cnt}, {W'(f_sig), CW'(f_cnt)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; golden = '0; exp_cnt = '0;
    idle_inputs();
    tick(); tick();
    check("reset_outputs", {sig, cnt, busy, done, pass}, '0);
    rstn = 1'b1;
    tick();

    run_stream(8'h1D, 4'd4, 1'b1, "match");
    run_stream(8'h1C, 4'd4, 1'b0, "bad_sig");
    run_stream(8'h1D, 4'd5, 1'b0, "bad_cnt");

    // Beat together with last, then restart from DONE.
    golden = 8'h80; exp_cnt = 4'd3;
    do_start();
    valid = 1'b1; data = 8'h01; tick();
    data = 8'h02; tick();
    data = 8'h80; last = 1'b1; tick();
    valid = 1'b0; last = 1'b0;
    check("beat_on_last_sig", sig, 8'h80);
    check("beat_on_last_cnt", cnt, 3);
    tick();
    check("beat_on_last_pass", {done, pass}, 2'b11);
    do_start();
    check("restart_regs", {sig, cnt}, '0);
    check("restart_flags", {busy, done, pass}, 3'b100);

    // Start and last together: start wins, block keeps compacting.
    valid = 1'b1; data = 8'h55; tick();
    valid = 1'b0; start = 1'b1; last = 1'b1; tick();
    start = 1'b0; last = 1'b0;
    check("start_beats_last", {sig, cnt, busy, done}, {8'h00, 4'd0, 2'b10});
    tick();
    check("start_beats_last_hold", {busy, done}, 2'b10);

    // Asynchronous reset mid-compaction.
    do_start();
    valid = 1'b1; data = 8'h3C; tick();
    data = 8'h99; tick();
    valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("async_reset", {sig, cnt, busy, done, pass}, '0);
    tick();
    rstn = 1'b1;
    valid = 1'b1; data = 8'hA5;
    tick(); tick(); tick();
    valid = 1'b0;
    check("idle_ignores_beats", {sig, cnt, busy, done}, '0);

    // Saturation with matching all-ones expectation, then random runs.
    run_random(18);
    for (int r = 0; r < 40; r++) run_random($urandom_range(0, 20));

`ifdef BIST_MISR_TIMEOUT_EN
    golden = 8'h00; exp_cnt = 4'd0;
    do_start();
    for (int i = 0; i < 8; i++) tick();
    check("tmo_not_yet", {tmo, busy, done}, 3'b010);
    tick();
    check("tmo_check", {tmo, busy, done}, 3'b110);
    tick();
    check("tmo_done", {tmo, done, pass}, 3'b110);
    do_start();
    check("tmo_cleared", {tmo, busy}, 2'b01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
